// File: rtl/wavegen_axil_master.sv
// wavegen_axil_master: AXI4-lite initiator for the wavegen register slave.
// Turns single-beat sequencer commands into AXI4-lite writes (AW+W issued
// together) or reads, one transaction outstanding, and returns the result
// on the rsp_* channel. Every bus output comes straight from a register.
// Optional build macro WAVEGEN_AXIL_MASTER_STATS_EN adds saturating
// wr_count / rd_count / err_count outputs.
`timescale 1ns/1ps

module wavegen_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    // sequencer command channel
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    input  logic [3:0]                    cmd_wstrb,
    // sequencer response channel
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_write,
    // AXI4-lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    // AXI4-lite write data
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    // AXI4-lite write response
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    // AXI4-lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    // AXI4-lite read data
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
    ,
    output logic [15:0]                   wr_count,
    output logic [15:0]                   rd_count,
    output logic [7:0]                    err_count
`endif
);

    generate
        if (C_M_AXI_DATA_WIDTH != 32 || C_M_AXI_ADDR_WIDTH < 3) begin : g_bad_param
            $error("wavegen_axil_master: data width must be 32 and address width at least 3");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    // Word alignment: the two byte-lane bits are cleared before reaching the bus.
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] C_ADDR_KEEP = {{(C_M_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [2:0]                    r_state;
    logic                          r_cmd_ready;
    logic                          r_write;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                   r_wdata;
    logic [3:0]                    r_wstrb;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic                          r_arvalid;
    logic                          r_rready;
    logic                          r_rsp_valid;
    logic [31:0]                   r_rsp_rdata;
    logic [1:0]                    r_rsp_resp;
    logic                          r_rsp_write;

    logic                          w_cmd_fire;
    logic                          w_b_fire;
    logic                          w_r_fire;
    logic [C_M_AXI_ADDR_WIDTH-1:0] w_addr_aligned;

    assign w_cmd_fire     = cmd_valid & r_cmd_ready;
    assign w_b_fire       = (r_state == S_WRESP) & M_AXI_BVALID & r_bready;
    assign w_r_fire       = (r_state == S_RDATA) & M_AXI_RVALID & r_rready;
    assign w_addr_aligned = cmd_addr & C_ADDR_KEEP;

    // Transaction sequencer: command accept, AXI handshakes, response hold.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_rsp_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // cmd_ready is registered, so it appears one cycle after
                    // entering IDLE and drops on the accepting edge.
                    r_cmd_ready <= !w_cmd_fire && !r_rsp_valid;
                    if (w_cmd_fire) begin
                        r_write <= cmd_write;
                        r_addr  <= w_addr_aligned;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
                    // Both VALIDs already low means both handshakes are done;
                    // BREADY follows one cycle after the last of them.
                    if (!r_awvalid && !r_wvalid) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (w_b_fire) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_write <= r_write;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (w_r_fire) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_write <= r_write;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
    logic [15:0] r_wr_count;
    logic [15:0] r_rd_count;
    logic [7:0]  r_err_count;
    logic        w_err_fire;

    assign w_err_fire = (w_b_fire && (M_AXI_BRESP != 2'b00)) ||
                        (w_r_fire && (M_AXI_RRESP != 2'b00));

    // Saturating completion and error counters.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_err_count <= '0;
        end else begin
            if (w_b_fire && (r_wr_count != '1))    r_wr_count  <= r_wr_count + 16'd1;
            if (w_r_fire && (r_rd_count != '1))    r_rd_count  <= r_rd_count + 16'd1;
            if (w_err_fire && (r_err_count != '1)) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign wr_count  = r_wr_count;
    assign rd_count  = r_rd_count;
    assign err_count = r_err_count;
`endif

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_write     = r_rsp_write;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_wavegen_axil_master.sv
// Testbench for wavegen_axil_master: table of directed transactions against
// a configurable-latency AXI4-lite slave model, plus hand-written sequences
// for handshake skew, response back-pressure, back-to-back and mid-read reset.
`timescale 1ns/1ps

module tb_wavegen_axil_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic [5:0]  M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [5:0]  M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic [7:0]  err_count;
`endif

    wavegen_axil_master #(
        .C_M_AXI_ADDR_WIDTH(6),
        .C_M_AXI_DATA_WIDTH(32)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_write     (rsp_write),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
        ,
        .wr_count      (wr_count),
        .rd_count      (rd_count),
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Free-running cycle number, read at negedges to measure latency.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Slave model: each READY rises after cfg_*_d cycles of VALID waiting,
    // BVALID / RVALID after cfg_b_d / cfg_r_d cycles; byte-strobed memory.
    // cfg_b_early raises BVALID as soon as W is taken, before AW.
    // ------------------------------------------------------------------
    int         cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
    logic [1:0] cfg_resp = 2'b00;
    logic       cfg_b_early = 1'b0;

    int          s_aw_cnt, s_w_cnt, s_b_cnt, s_ar_cnt, s_r_cnt;
    logic        s_aw_got, s_w_got, s_ar_got;
    logic [5:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_mem [0:15];

    assign M_AXI_AWREADY = !s_aw_got && (s_aw_cnt >= cfg_aw_d);
    assign M_AXI_WREADY  = !s_w_got && (s_w_cnt >= cfg_w_d);
    assign M_AXI_BVALID  = (s_aw_got && s_w_got && (s_b_cnt >= cfg_b_d)) || (cfg_b_early && s_w_got);
    assign M_AXI_BRESP   = cfg_resp;
    assign M_AXI_ARREADY = !s_ar_got && (s_ar_cnt >= cfg_ar_d);
    assign M_AXI_RVALID  = s_ar_got && (s_r_cnt >= cfg_r_d);
    assign M_AXI_RDATA   = M_AXI_RVALID ? s_mem[s_araddr[5:2]] : 32'h0;
    assign M_AXI_RRESP   = cfg_resp;

    always @(posedge clk) begin
        if (rst) begin
            s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_ar_got <= 1'b0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
            for (int i = 0; i < 16; i++) s_mem[i] <= '0;
        end else begin
            if (M_AXI_AWVALID && !s_aw_got) begin
                if (M_AXI_AWREADY) begin s_aw_got <= 1'b1; s_awaddr <= M_AXI_AWADDR; end
                else s_aw_cnt <= s_aw_cnt + 1;
            end
            if (M_AXI_WVALID && !s_w_got) begin
                if (M_AXI_WREADY) begin s_w_got <= 1'b1; s_wdata <= M_AXI_WDATA; s_wstrb <= M_AXI_WSTRB; end
                else s_w_cnt <= s_w_cnt + 1;
            end
            if (s_aw_got && s_w_got && !M_AXI_BVALID) s_b_cnt <= s_b_cnt + 1;
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                for (int i = 0; i < 4; i++)
                    if (s_wstrb[i]) s_mem[s_awaddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
                s_aw_got <= 1'b0; s_w_got <= 1'b0;
                s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0;
            end
            if (M_AXI_ARVALID && !s_ar_got) begin
                if (M_AXI_ARREADY) begin s_ar_got <= 1'b1; s_araddr <= M_AXI_ARADDR; end
                else s_ar_cnt <= s_ar_cnt + 1;
            end
            if (s_ar_got && !M_AXI_RVALID) s_r_cnt <= s_r_cnt + 1;
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                s_ar_got <= 1'b0; s_ar_cnt <= 0; s_r_cnt <= 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                             input logic [1:0] resp, input logic early);
        cfg_aw_d = aw; cfg_w_d = w; cfg_b_d = b; cfg_ar_d = ar; cfg_r_d = r;
        cfg_resp = resp; cfg_b_early = early;
    endtask

    // Offer a command from a negedge; return the cycle it was accepted in.
    // Leaves the caller at the negedge one cycle after acceptance.
    task automatic issue_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string tag, output int acc);
        bit ok = 1'b0;
        acc = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin ok = 1'b1; acc = cyc; break; end
            @(negedge clk);
        end
        chk({tag, "_accepted"}, {31'd0, ok}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int t);
        bit ok = 1'b0;
        t = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin ok = 1'b1; t = cyc; break; end
            @(negedge clk);
        end
        chk({tag, "_rsp_seen"}, {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  sresp;
        logic [5:0]  exp_addr;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [7];

    task automatic run_txn(input vec_t v, input string tag);
        int acc, t;
        set_slave(v.aw_d, v.w_d, v.b_d, v.ar_d, v.r_d, v.sresp, 1'b0);
        issue_cmd(v.wr, v.addr, v.wdata, v.wstrb, tag, acc);
        if (v.wr) begin
            chk({tag, "_valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b110);
            chk({tag, "_awaddr"}, M_AXI_AWADDR, v.exp_addr);
            chk({tag, "_wdata"}, M_AXI_WDATA, v.wdata);
            chk({tag, "_wstrb"}, M_AXI_WSTRB, v.wstrb);
        end else begin
            chk({tag, "_valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b001);
            chk({tag, "_araddr"}, M_AXI_ARADDR, v.exp_addr);
        end
        wait_rsp(tag, t);
        chk({tag, "_latency"}, t - acc, v.exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_resp"}, rsp_resp, v.exp_resp);
        chk({tag, "_rsp_write"}, rsp_write, v.wr);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_after_rsp"}, {rsp_valid, cmd_ready}, 2'b00);
        @(negedge clk);
        chk({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
    endtask

    // {AWVALID, WVALID, BREADY} for cycles 1..6 after a write accepted with
    // WREADY immediate and AWREADY three cycles later.
    logic [2:0] skew_exp [1:6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, t, h, n;
        int accs [2];
        logic busy_bad;

        vecs[0] = '{1'b1, 6'h08, 32'h00012345, 4'hF,   0, 0, 0, 0, 0, 2'b00, 6'h08, 4, 32'h0,        2'b00};
        vecs[1] = '{1'b0, 6'h08, 32'h0,        4'h0,   0, 0, 0, 0, 0, 2'b00, 6'h08, 3, 32'h00012345, 2'b00};
        vecs[2] = '{1'b1, 6'h0F, 32'hA5A55A5A, 4'b0101, 2, 1, 0, 0, 0, 2'b00, 6'h0C, 6, 32'h0,        2'b00};
        vecs[3] = '{1'b0, 6'h0D, 32'h0,        4'h0,   0, 0, 0, 1, 2, 2'b00, 6'h0C, 6, 32'h00A5005A, 2'b00};
        vecs[4] = '{1'b1, 6'h20, 32'hDEADBEEF, 4'hF,   0, 0, 5, 0, 0, 2'b10, 6'h20, 8, 32'h0,        2'b10};
        vecs[5] = '{1'b0, 6'h20, 32'h0,        4'h0,   0, 0, 0, 0, 0, 2'b11, 6'h20, 3, 32'hDEADBEEF, 2'b11};
        vecs[6] = '{1'b0, 6'h04, 32'h0,        4'h0,   0, 0, 0, 0, 0, 2'b00, 6'h04, 3, 32'h0,        2'b00};

        skew_exp[1] = 3'b110; skew_exp[2] = 3'b100; skew_exp[3] = 3'b100;
        skew_exp[4] = 3'b100; skew_exp[5] = 3'b000; skew_exp[6] = 3'b001;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_handshakes", {cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID,
                               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 7'b0);
        chk("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB}, 16'h0);
        chk("rst_wdata", M_AXI_WDATA, 32'h0);
        chk("rst_rsp", {rsp_rdata[31:2], rsp_rdata[1:0] | rsp_resp}, 32'h0);
        chk("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 6'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
            if (i == 4) chk("err_count_after_slverr", err_count, 8'd1);
`endif
        end

        // WREADY three cycles ahead of AWREADY, BVALID offered early
        set_slave(3, 0, 0, 0, 0, 2'b00, 1'b1);
        issue_cmd(1'b1, 6'h14, 32'hCAFE0001, 4'hF, "skew", acc);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("skew_c%0d_awv_wv_bready", k), {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, skew_exp[k]);
            if (k <= 4) chk($sformatf("skew_c%0d_awaddr", k), M_AXI_AWADDR, 6'h14);
            @(negedge clk);
        end
        wait_rsp("skew", t);
        chk("skew_latency", t - acc, 7);
        chk("skew_resp", {rsp_write, rsp_resp}, 3'b100);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);

        // Response back-pressure with a second command already queued
        set_slave(0, 0, 0, 0, 0, 2'b00, 1'b0);
        issue_cmd(1'b1, 6'h10, 32'h11112222, 4'hF, "bp_wr", acc);
        cmd_write = 1'b0; cmd_addr = 6'h10; cmd_valid = 1'b1;
        busy_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) break;
            if (cmd_ready) busy_bad = 1'b1;
            @(negedge clk);
        end
        chk("busy_cmd_ignored", busy_bad, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold%0d", k), {rsp_valid, cmd_ready}, 2'b10);
            @(negedge clk);
        end
        chk("bp_rdata", rsp_rdata, 32'h0);
        chk("bp_resp_write", {rsp_write, rsp_resp}, 3'b100);
        rsp_ready = 1'b1;
        h = cyc;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_h1_not_ready", {rsp_valid, cmd_ready}, 2'b00);
        @(negedge clk);
        chk("bp_h2_ready", cmd_ready, 1'b1);
        chk("bp_accept_gap", cyc - h, 2);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_rd_arvalid", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 6'h10});
        wait_rsp("bp_rd", t);
        chk("bp_rd_latency", t - acc, 3);
        chk("bp_rd_rdata", rsp_rdata, 32'h11112222);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);

        // Back-to-back reads with rsp_ready held high
        rsp_ready = 1'b1;
        cmd_write = 1'b0; cmd_addr = 6'h0C; cmd_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (cmd_ready) begin accs[n] = cyc; n++; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("b2b_two_accepts", n, 2);
        chk("b2b_period", accs[1] - accs[0], 5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin n = 1; break; end
            @(negedge clk);
        end
        chk("b2b_idle_again", n, 1);
        rsp_ready = 1'b0;

`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
        chk("wr_count", wr_count, 16'd5);
        chk("rd_count", rd_count, 16'd7);
        chk("err_count", err_count, 8'd2);
`endif

        // Reset while ARVALID is waiting for ARREADY
        set_slave(0, 0, 0, 10, 0, 2'b00, 1'b0);
        issue_cmd(1'b0, 6'h08, 32'h0, 4'h0, "rst_rd", acc);
        chk("rst_rd_arvalid", M_AXI_ARVALID, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_cleared", {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready}, 4'b0);
        rst = 1'b0;
        busy_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid || M_AXI_ARVALID) busy_bad = 1'b1;
        end
        chk("rst_rd_no_rsp", busy_bad, 1'b0);
        chk("rst_rd_idle", cmd_ready, 1'b1);
        run_txn(vecs[6], "after_rst");
`ifdef WAVEGEN_AXIL_MASTER_STATS_EN
        chk("stats_after_rst", {wr_count, rd_count, err_count}, {16'd0, 16'd1, 8'd0});
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
